// File: rtl/lsu_axi_master_pkg.sv
// Shared definitions for the LSU-to-AXI single-beat initiator: FSM states,
// AXI response codes and the CLINT register addresses used by benches.
package lsu_axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4
    } lsu_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] CLINT_MTIMECMP = 32'h0200_4000;
    localparam logic [31:0] CLINT_MTIME    = 32'h0200_BFF8;

endpackage

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4-Lite-style initiator: turns one LSU read/write request
// into AR/R or AW/W/B handshakes and returns a one-cycle completion pulse.
module lsu_axi_master
    import lsu_axi_master_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wen,
    input  logic [AXI_ADDR_WIDTH-1:0]     req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                          resp_valid,
    output logic [AXI_DATA_WIDTH-1:0]     resp_rdata,
    output logic                          resp_err,
    output logic                          axi_aw_valid_o,
    input  logic                          axi_aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_o,
    output logic                          axi_w_valid_o,
    input  logic                          axi_w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     axi_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_o,
    input  logic                          axi_b_valid_i,
    output logic                          axi_b_ready_o,
    input  logic [1:0]                    axi_b_resp_i,
    output logic                          axi_ar_valid_o,
    input  logic                          axi_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_o,
    input  logic                          axi_r_valid_i,
    output logic                          axi_r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_r_data_i,
    input  logic [1:0]                    axi_r_resp_i
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    lsu_state_e                state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic                      aw_done;
    logic                      w_done;

    logic aw_fire;
    logic w_fire;
    logic aw_done_nxt;
    logic w_done_nxt;

    assign req_ready = (state == ST_IDLE);

    // Address/data come straight from the latch so they stay stable under valid.
    assign axi_aw_addr_o = addr_q;
    assign axi_ar_addr_o = addr_q;
    assign axi_w_data_o  = wdata_q;
    assign axi_w_strb_o  = wstrb_q;

    assign aw_fire     = axi_aw_valid_o & axi_aw_ready_i;
    assign w_fire      = axi_w_valid_o & axi_w_ready_i;
    assign aw_done_nxt = aw_done | aw_fire;
    assign w_done_nxt  = w_done | w_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            axi_aw_valid_o <= 1'b0;
            axi_w_valid_o  <= 1'b0;
            axi_b_ready_o  <= 1'b0;
            axi_ar_valid_o <= 1'b0;
            axi_r_ready_o  <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (req_wen) begin
                            axi_aw_valid_o <= 1'b1;
                            axi_w_valid_o  <= 1'b1;
                            aw_done        <= 1'b0;
                            w_done         <= 1'b0;
                            state          <= ST_WREQ;
                        end else begin
                            axi_ar_valid_o <= 1'b1;
                            state          <= ST_RADDR;
                        end
                    end
                end
                ST_RADDR: begin
                    if (axi_ar_valid_o && axi_ar_ready_i) begin
                        axi_ar_valid_o <= 1'b0;
                        axi_r_ready_o  <= 1'b1;
                        state          <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (axi_r_valid_i && axi_r_ready_o) begin
                        axi_r_ready_o <= 1'b0;
                        resp_rdata    <= axi_r_data_i;
                        resp_err      <= (axi_r_resp_i != RESP_OKAY);
                        resp_valid    <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_WREQ: begin
                    // AW and W retire independently; move on once both have.
                    if (aw_fire) begin
                        axi_aw_valid_o <= 1'b0;
                        aw_done        <= 1'b1;
                    end
                    if (w_fire) begin
                        axi_w_valid_o <= 1'b0;
                        w_done        <= 1'b1;
                    end
                    if (aw_done_nxt && w_done_nxt) begin
                        axi_b_ready_o <= 1'b1;
                        state         <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (axi_b_valid_i && axi_b_ready_o) begin
                        axi_b_ready_o <= 1'b0;
                        resp_err      <= (axi_b_resp_i != RESP_OKAY);
                        resp_valid    <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a delay-configurable AXI slave model,
// a response scoreboard and a handshake-stability monitor.
module tb_lsu_axi_master;
    import lsu_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        axi_aw_valid_o;
    logic        axi_aw_ready_i = 1'b0;
    logic [31:0] axi_aw_addr_o;
    logic        axi_w_valid_o;
    logic        axi_w_ready_i = 1'b0;
    logic [63:0] axi_w_data_o;
    logic [7:0]  axi_w_strb_o;
    logic        axi_b_valid_i = 1'b0;
    logic        axi_b_ready_o;
    logic [1:0]  axi_b_resp_i = '0;
    logic        axi_ar_valid_o;
    logic        axi_ar_ready_i = 1'b0;
    logic [31:0] axi_ar_addr_o;
    logic        axi_r_valid_i = 1'b0;
    logic        axi_r_ready_o;
    logic [63:0] axi_r_data_i = '0;
    logic [1:0]  axi_r_resp_i = '0;

    lsu_axi_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i), .axi_aw_addr_o(axi_aw_addr_o),
        .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
        .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
        .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o), .axi_b_resp_i(axi_b_resp_i),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_addr_o(axi_ar_addr_o),
        .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
        .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Slave configuration and state
    int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    int          aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    logic [1:0]  b_rsp = 2'b00, r_rsp = 2'b00;
    logic [63:0] r_dat = '0;
    logic [63:0] mtimecmp = '0;
    logic [31:0] s_awaddr = '0;
    logic [63:0] s_wdata = '0;
    logic [7:0]  s_wstrb = '0;
    logic [63:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave model: ready/valid decided on the falling edge from stable DUT outputs.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_ar_ready_i = 0;
            axi_b_valid_i = 0; axi_r_valid_i = 0; axi_b_resp_i = 0; axi_r_resp_i = 0;
            aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        end else begin
            axi_aw_ready_i = axi_aw_valid_o && (aw_c >= aw_d);
            if (axi_aw_ready_i) s_awaddr = axi_aw_addr_o;
            aw_c = axi_aw_valid_o ? aw_c + 1 : 0;

            axi_w_ready_i = axi_w_valid_o && (w_c >= w_d);
            if (axi_w_ready_i) begin
                s_wdata = axi_w_data_o;
                s_wstrb = axi_w_strb_o;
            end
            w_c = axi_w_valid_o ? w_c + 1 : 0;

            axi_ar_ready_i = axi_ar_valid_o && (ar_c >= ar_d);
            ar_c = axi_ar_valid_o ? ar_c + 1 : 0;

            if (axi_b_ready_o && b_c >= b_d) begin
                axi_b_valid_i = 1;
                axi_b_resp_i  = b_rsp;
                if (s_awaddr == CLINT_MTIMECMP)
                    for (int i = 0; i < 8; i++)
                        if (s_wstrb[i]) mtimecmp[8*i +: 8] = s_wdata[8*i +: 8];
            end else begin
                axi_b_valid_i = 0;
                axi_b_resp_i  = 0;
            end
            b_c = axi_b_ready_o ? b_c + 1 : 0;

            if (axi_r_ready_o && r_c >= r_d) begin
                axi_r_valid_i = 1;
                axi_r_resp_i  = r_rsp;
                axi_r_data_i  = r_dat;
            end else begin
                axi_r_valid_i = 0;
                axi_r_resp_i  = 0;
            end
            r_c = axi_r_ready_o ? r_c + 1 : 0;
        end
    end

    // Scoreboard: every completion pulse must match the oldest expectation.
    initial forever begin
        @(posedge clk);
        #1;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_resp", resp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdata", resp_rdata, e.rdata);
                chk("sb_err", resp_err, e.err);
            end
        end
    end

    // Protocol monitor: a pending valid and its payload must survive until handshake.
    initial forever begin
        logic        p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [31:0] p_awa, p_ara;
        logic [63:0] p_wd;
        logic [7:0]  p_ws;
        @(posedge clk);
        p_rst = rst;
        p_awv = axi_aw_valid_o; p_awr = axi_aw_ready_i; p_awa = axi_aw_addr_o;
        p_wv = axi_w_valid_o; p_wr = axi_w_ready_i; p_wd = axi_w_data_o; p_ws = axi_w_strb_o;
        p_arv = axi_ar_valid_o; p_arr = axi_ar_ready_i; p_ara = axi_ar_addr_o;
        #1;
        if (p_rst && rst) begin
            if (p_awv && !p_awr) chk("mon_aw_hold", {axi_aw_valid_o, axi_aw_addr_o}, {1'b1, p_awa});
            if (p_wv && !p_wr) begin
                chk("mon_w_hold", {axi_w_valid_o, axi_w_strb_o}, {1'b1, p_ws});
                chk("mon_w_data", axi_w_data_o, p_wd);
            end
            if (p_arv && !p_arr) chk("mon_ar_hold", {axi_ar_valid_o, axi_ar_addr_o}, {1'b1, p_ara});
            if (axi_b_ready_o) chk("mon_b_ready_excl", axi_aw_valid_o | axi_w_valid_o, 1'b0);
            if (axi_r_ready_o) chk("mon_r_ready_excl", axi_ar_valid_o, 1'b0);
        end
    end

    task automatic issue(input logic wen, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int n = 0;
        @(negedge clk);
        req_valid = 1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid = 0;
    endtask

    // Latency counts the acceptance cycle as the first one.
    task automatic wait_resp(input string tag, input int exp_lat);
        int   n = 0;
        logic found = 0;
        while (!found && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            found = resp_valid;
        end
        chk({tag, "_seen"}, found, 1'b1);
        chk({tag, "_latency"}, cyc - acc_cyc + 1, exp_lat);
    endtask

    initial begin
        int   n;
        logic found;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_valids", {axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o, axi_b_ready_o, axi_r_ready_o}, 5'b0);
        chk("rst_resp", {resp_valid, resp_err}, 2'b0);
        chk("rst_rdata", resp_rdata, 64'h0);
        chk("rst_latch", {axi_ar_addr_o, axi_w_strb_o}, 40'h0);
        chk("rst_wdata", axi_w_data_o, 64'h0);
        @(negedge clk);
        rst = 1;

        // Zero-wait write to mtimecmp
        push_exp(last_rdata, 1'b0);
        issue(1'b1, CLINT_MTIMECMP, 64'h100, 8'hFF);
        chk("wr0_aw_w_valid", {axi_aw_valid_o, axi_w_valid_o}, 2'b11);
        chk("wr0_aw_addr", axi_aw_addr_o, CLINT_MTIMECMP);
        chk("wr0_w_data", axi_w_data_o, 64'h100);
        wait_resp("wr0", 3);
        chk("wr0_mtimecmp", mtimecmp, 64'h100);

        // Read with delayed r_valid
        r_d = 4; r_dat = 64'h1234;
        push_exp(r_dat, 1'b0);
        last_rdata = r_dat;
        issue(1'b0, CLINT_MTIME, 64'h0, 8'h0);
        chk("rd0_ar", {axi_ar_valid_o, axi_ar_addr_o}, {1'b1, CLINT_MTIME});
        @(posedge clk);
        #1;
        chk("rd0_after_ar", {axi_ar_valid_o, axi_r_ready_o}, 2'b01);
        wait_resp("rd0", 3 + r_d);
        @(posedge clk);
        #1;
        chk("rd0_pulse_one_cycle", resp_valid, 1'b0);
        r_d = 0;

        // Skewed write: W lags AW
        w_d = 3;
        push_exp(last_rdata, 1'b0);
        issue(1'b1, CLINT_MTIMECMP, 64'h1122_3344_5566_AABB, 8'h0F);
        @(posedge clk);
        #1;
        chk("sk1_mid", {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o}, 3'b010);
        chk("sk1_w_data", axi_w_data_o, 64'h1122_3344_5566_AABB);
        wait_resp("sk1", 6);
        chk("sk1_mtimecmp", mtimecmp, 64'h0000_0000_5566_AABB);

        // Skewed write: AW lags W
        w_d = 0; aw_d = 3;
        push_exp(last_rdata, 1'b0);
        issue(1'b1, CLINT_MTIMECMP, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        @(posedge clk);
        #1;
        chk("sk2_mid", {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o}, 3'b100);
        chk("sk2_aw_addr", axi_aw_addr_o, CLINT_MTIMECMP);
        wait_resp("sk2", 6);
        chk("sk2_mtimecmp", mtimecmp, 64'hDEAD_BEEF_0000_0001);
        aw_d = 0;

        // Error responses
        b_rsp = RESP_SLVERR;
        push_exp(last_rdata, 1'b1);
        issue(1'b1, CLINT_MTIMECMP, 64'h5, 8'h01);
        wait_resp("werr", 3);
        b_rsp = RESP_OKAY;
        chk("werr_idle", req_ready, 1'b1);
        r_rsp = RESP_DECERR; r_dat = 64'hBAD0;
        push_exp(r_dat, 1'b1);
        last_rdata = r_dat;
        issue(1'b0, 32'h1000_0000, 64'h0, 8'h0);
        wait_resp("rerr", 3);
        r_rsp = RESP_OKAY;
        chk("rerr_idle", req_ready, 1'b1);

        // Back-to-back: read held through its response, then a write
        r_dat = 64'h5555_AAAA_0000_1111;
        push_exp(r_dat, 1'b0);
        last_rdata = r_dat;
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_addr = CLINT_MTIME;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        chk("b2b_busy", req_ready, 1'b0);
        n = 0; found = 0;
        while (!found && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            found = resp_valid;
        end
        chk("b2b_rd_seen", found, 1'b1);
        chk("b2b_rd_latency", cyc - acc_cyc + 1, 3);
        chk("b2b_ready_in_resp", req_ready, 1'b1);
        push_exp(last_rdata, 1'b0);
        req_wen = 1; req_addr = CLINT_MTIMECMP; req_wdata = 64'h77; req_wstrb = 8'hFF;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid = 0;
        chk("b2b_wr_accepted", {axi_aw_valid_o, axi_w_valid_o, req_ready}, 3'b110);
        chk("b2b_pulse_end", resp_valid, 1'b0);
        wait_resp("b2b_wr", 3);
        chk("b2b_mtimecmp", mtimecmp, 64'h77);

        // Reset while waiting in RDATA
        r_d = 20;
        issue(1'b0, CLINT_MTIME, 64'h0, 8'h0);
        n = 0; found = 0;
        while (!found && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            found = axi_r_ready_o;
        end
        chk("rrst_r_ready_seen", found, 1'b1);
        #2;
        rst = 0;
        #1;
        chk("rrst_valids", {axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o, axi_b_ready_o, axi_r_ready_o}, 5'b0);
        chk("rrst_resp", {resp_valid, resp_err}, 2'b0);
        chk("rrst_rdata", resp_rdata, 64'h0);
        chk("rrst_latch", {axi_ar_addr_o, axi_w_strb_o}, 40'h0);
        chk("rrst_wdata", axi_w_data_o, 64'h0);
        chk("rrst_req_ready", req_ready, 1'b1);
        last_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        r_d = 0; r_dat = 64'h600D;
        push_exp(r_dat, 1'b0);
        last_rdata = r_dat;
        issue(1'b0, CLINT_MTIME, 64'h0, 8'h0);
        wait_resp("rrst_fresh", 3);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- AXI4-Lite-style single-beat initiator between the core load/store unit and the data-side bus.
- Converts one simple LSU request (read or write) into AR/R or AW/W/B transactions toward bus slaves such as the CLINT, and returns data/status to the LSU.
- Exactly one transaction outstanding; no bursts, no IDs.

Parameters:
- AXI_DATA_WIDTH, 64, data bus width; the strobe is AXI_DATA_WIDTH/8 bits.
- AXI_ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSU request present.
- req_ready  out  1  master can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  AXI_ADDR_WIDTH  byte address, passed unaltered.
- req_wdata  in  AXI_DATA_WIDTH  write data, lane-aligned by the LSU.
- req_wstrb  in  AXI_DATA_WIDTH/8  byte strobes.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  AXI_DATA_WIDTH  read data; meaningful for reads only.
- resp_err  out  1  bus returned SLVERR/DECERR.
- axi_aw_valid_o, axi_aw_ready_i, axi_aw_addr_o: write-address channel.
- axi_w_valid_o, axi_w_ready_i, axi_w_data_o, axi_w_strb_o: write-data channel.
- axi_b_valid_i, axi_b_ready_o, axi_b_resp_i[1:0]: write-response channel.
- axi_ar_valid_o, axi_ar_ready_i, axi_ar_addr_o: read-address channel.
- axi_r_valid_i, axi_r_ready_o, axi_r_data_i, axi_r_resp_i[1:0]: read-data channel.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all axi_*_valid_o, axi_b_ready_o, axi_r_ready_o, resp_valid, resp_err = 0; resp_rdata, latched address/data/strobe = 0.
- States: IDLE, RADDR, RDATA, WREQ, WRESP.
- req_ready = (state == IDLE); combinational from state only, never from req_valid.
- IDLE, req_valid=1:
  - Latch addr/wdata/wstrb.
  - Read: go to RADDR and register axi_ar_valid_o=1 on the same edge.
  - Write: go to WREQ and register axi_aw_valid_o=1 and axi_w_valid_o=1 on the same edge.
- RADDR: hold ar_valid and ar_addr stable until ar_ready. On the handshake edge: ar_valid<=0, r_ready<=1, go to RDATA.
- RDATA: on r_valid & r_ready:
  - r_ready<=0; resp_rdata<=r_data; resp_err<=(r_resp != 0); resp_valid<=1; go to IDLE.
- WREQ: AW and W complete independently.
  - Each valid drops on the edge of its own handshake; an internal done flag records it.
  - Both handshakes may occur in the same cycle, or in either order, with any number of cycles between them.
  - When both are done (including the cycle the last one completes): b_ready<=1, go to WRESP.
  - Address and data stay stable while their valid is high.
- WRESP: on b_valid & b_ready: b_ready<=0; resp_err<=(b_resp != 0); resp_valid<=1; go to IDLE.
  - resp_rdata holds its previous value on writes.
- resp_valid is high for exactly one cycle, the first cycle back in IDLE. The LSU must consume it; there is no backpressure.
  - A new request may be accepted in that same cycle (req_ready=1).
  - Minimum turnaround: 3 cycles from acceptance to resp_valid with zero-wait slaves.
- AXI rules: a valid is never withdrawn before its handshake. Valid never depends combinationally on ready. r_ready/b_ready are asserted only in RDATA/WRESP.
- R/B beats arriving outside their state are ignored and not acknowledged.
- Error responses complete normally with resp_err=1; there is no retry.
- Reset mid-transaction: aborts immediately, no resp_valid is produced. A system-wide reset also clears the slaves.
- Timing: no combinational path from any AXI input to any AXI output or to req_ready.

Decomposition:
- Shared package: state encoding constants, AXI resp codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), and the CLINT addresses MTIMECMP=0x0200_4000 and MTIME=0x0200_BFF8 for benches.
- Single module; the AW/W dual-completion tracking is small enough to stay inline, so no sub-module.

Test Plan:
- Write, zero-wait CLINT model: req_wen=1, addr 0x0200_4000, wdata 0x100, wstrb 0xFF -> AW and W valid together one cycle after acceptance; resp_valid 3 cycles after acceptance, resp_err=0; slave mtimecmp = 0x100.
- Read, slave with 4-cycle r_valid delay: addr 0x0200_BFF8, slave returns 0x1234 -> ar_valid drops after ar_ready, r_ready held; resp_rdata=0x1234, resp_err=0, one-cycle pulse.
- Skewed write: w_ready 3 cycles after aw_ready, then the reverse order -> each valid drops only at its own handshake, WRESP entered only after both, data stable throughout.
- Error: b_resp=2 on a write, then r_resp=3 on a read -> resp_err=1 for each; state returns to IDLE; the next request is accepted.
- Back-to-back: read request held high through resp_valid, followed by a write -> second acceptance in the resp_valid cycle; no valid ever drops pre-handshake (assertion-checked).
- Reset mid-RDATA: rst low while r_ready=1 -> all outputs 0 asynchronously, no resp_valid; after release, req_ready=1 and a fresh read completes normally.
